// File: rtl/packet_write_scheduler.sv
// packet_write_scheduler
// Packet-level round-robin scheduler for the shared-cache write port. It picks
// one requesting ingress port with a rotating priority pointer, holds the grant
// for that port's whole packet and streams the packet word by word to the cache
// write interface. A beat happens in every transfer cycle with i_mem_ready=1.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req            per-port "complete packet available"
//   i_len            per-port head packet length in words (slice k = port k)
//   i_data           per-port FIFO head word (slice k = port k)
//   i_mem_ready      downstream accepts a write this cycle
//   o_ack            one-hot pop strobe to the granted port's FIFO
//   o_grant          one-hot granted port while transferring, else 0
//   o_wr_en          write beat valid
//   o_wr_data        write word
//   o_wr_port        source port of the beat
//   o_sop, o_eop     first / last beat of packet
//   o_busy           transfer in progress
module packet_write_scheduler #(
  parameter int unsigned N_PORT = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 6,
  localparam int unsigned PORT_W = $clog2(N_PORT)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_PORT-1:0]         i_req,
  input  logic [N_PORT*LEN_W-1:0]   i_len,
  input  logic [N_PORT*DATA_W-1:0]  i_data,
  input  logic                      i_mem_ready,
  output logic [N_PORT-1:0]         o_ack,
  output logic [N_PORT-1:0]         o_grant,
  output logic                      o_wr_en,
  output logic [DATA_W-1:0]         o_wr_data,
  output logic [PORT_W-1:0]         o_wr_port,
  output logic                      o_sop,
  output logic                      o_eop,
  output logic                      o_busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state_q, state_d;
  logic [PORT_W-1:0]  ptr_q, ptr_d;
  logic [PORT_W-1:0]  gnt_q, gnt_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;

  logic [PORT_W-1:0]  sel;
  logic               beat;

  logic [LEN_W-1:0]   len_arr  [N_PORT];
  logic [DATA_W-1:0]  data_arr [N_PORT];

  // Unpack the flat per-port buses.
  for (genvar k = 0; k < N_PORT; k++) begin : g_unpack
    assign len_arr[k]  = i_len[k*LEN_W +: LEN_W];
    assign data_arr[k] = i_data[k*DATA_W +: DATA_W];
  end

  // Round-robin pick: first requester at or after ptr, wrapping at N_PORT.
  always_comb begin
    logic [PORT_W:0]   idx;
    logic [PORT_W-1:0] idx_n;
    logic              found;
    sel   = '0;
    idx   = '0;
    idx_n = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_PORT; i++) begin
      idx = (PORT_W+1)'(ptr_q) + (PORT_W+1)'(i);
      if (idx >= (PORT_W+1)'(N_PORT)) begin
        idx = idx - (PORT_W+1)'(N_PORT);
      end
      idx_n = PORT_W'(idx);
      if (!found && i_req[idx_n]) begin
        sel   = idx_n;
        found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Next-state and beat decode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    beat    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          gnt_d   = sel;
          // A zero length is illegal; treat it as a single-word packet.
          cnt_d   = (len_arr[sel] == '0) ? LEN_W'(1) : len_arr[sel];
          first_d = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (i_mem_ready) begin
          beat    = 1'b1;
          cnt_d   = cnt_q - LEN_W'(1);
          first_d = 1'b0;
          if (cnt_q == LEN_W'(1)) begin
            state_d = IDLE;
            ptr_d   = (gnt_q == PORT_W'(N_PORT-1)) ? '0 : PORT_W'(gnt_q + PORT_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state and i_mem_ready; all zero when idle.
  always_comb begin
    o_busy    = (state_q == XFER);
    o_grant   = '0;
    o_ack     = '0;
    o_wr_en   = beat;
    o_sop     = beat & first_q;
    o_eop     = beat & (cnt_q == LEN_W'(1));
    o_wr_data = '0;
    o_wr_port = '0;
    if (o_busy) begin
      o_grant   = N_PORT'(1) << gnt_q;
      o_wr_data = data_arr[gnt_q];
      o_wr_port = gnt_q;
    end
    if (beat) begin
      o_ack = N_PORT'(1) << gnt_q;
    end
  end

endmodule

// File: tb/tb_packet_write_scheduler.sv
// Bench for packet_write_scheduler: table of per-cycle vectors plus hand-written
// sequences for reset, mid-packet reset and round-robin fairness.
module tb_packet_write_scheduler;

  localparam int unsigned N_PORT = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned PORT_W = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [N_PORT-1:0]         req;
  logic [N_PORT*LEN_W-1:0]   len_bus;
  logic [N_PORT*DATA_W-1:0]  data_bus;
  logic                      ready;
  logic [N_PORT-1:0]         ack;
  logic [N_PORT-1:0]         grant;
  logic                      wr_en;
  logic [DATA_W-1:0]         wr_data;
  logic [PORT_W-1:0]         wr_port;
  logic                      sop;
  logic                      eop;
  logic                      busy;

  int checks = 0;
  int errors = 0;

  packet_write_scheduler #(.N_PORT(N_PORT), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_len(len_bus), .i_data(data_bus),
    .i_mem_ready(ready), .o_ack(ack), .o_grant(grant), .o_wr_en(wr_en),
    .o_wr_data(wr_data), .o_wr_port(wr_port), .o_sop(sop), .o_eop(eop), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] req;
    logic [5:0]  len;
    logic        rdy;
    logic [15:0] grant;
    logic        wr;
    logic [3:0]  port;
    logic        sop;
    logic        eop;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [15:0] r, logic [5:0] l, logic y, logic [15:0] g,
                              logic w, logic [3:0] p, logic s, logic e, logic b);
    vec_t v;
    v.req = r; v.len = l; v.rdy = y; v.grant = g; v.wr = w;
    v.port = p; v.sop = s; v.eop = e; v.busy = b;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] dval(int k);
    return DATA_W'(32'hC0DE_0000 + k * 257);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [15:0] r, input logic [5:0] l, input logic y);
    req   = r;
    ready = y;
    for (int k = 0; k < N_PORT; k++) len_bus[k*LEN_W +: LEN_W] = l;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] g, input logic w,
                         input logic [3:0] p, input logic s, input logic e, input logic b);
    logic [15:0] exp_ack;
    exp_ack = w ? (16'd1 << p) : 16'd0;
    chk({tag, " grant"}, 64'(grant), 64'(g));
    chk({tag, " wr_en"}, 64'(wr_en), 64'(w));
    chk({tag, " ack"},   64'(ack),   64'(exp_ack));
    chk({tag, " sop"},   64'(sop),   64'(s));
    chk({tag, " eop"},   64'(eop),   64'(e));
    chk({tag, " busy"},  64'(busy),  64'(b));
    if (b) chk({tag, " port"}, 64'(wr_port), 64'(p));
    if (w) chk({tag, " data"}, 64'(wr_data), 64'(dval(int'(p))));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " all-out"}, 64'({ack, grant, wr_en, wr_port, sop, eop, busy}), 64'(0));
    chk({tag, " wr_data"}, 64'(wr_data), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N_PORT; k++) data_bus[k*DATA_W +: DATA_W] = dval(k);
    rst_n = 1'b0;
    set_in(16'h0, 6'd1, 1'b0);

    // Port 3, len 4: grant one edge later, four beats, then idle.
    tbl.push_back(mk(16'h0008, 6'd4, 1, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(16'h0000, 6'd4, 1, 16'h0008, 1, 3, 1, 0, 1));
    tbl.push_back(mk(16'h0000, 6'd4, 1, 16'h0008, 1, 3, 0, 0, 1));
    tbl.push_back(mk(16'h0000, 6'd4, 1, 16'h0008, 1, 3, 0, 0, 1));
    tbl.push_back(mk(16'h0000, 6'd4, 1, 16'h0008, 1, 3, 0, 1, 1));
    tbl.push_back(mk(16'h0000, 6'd4, 1, 16'h0000, 0, 0, 0, 0, 0));
    // Port 6, len 3 under ready pattern 1,0,0,1,0,1.
    tbl.push_back(mk(16'h0040, 6'd3, 1, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(16'h0000, 6'd3, 1, 16'h0040, 1, 6, 1, 0, 1));
    tbl.push_back(mk(16'h0000, 6'd3, 0, 16'h0040, 0, 6, 0, 0, 1));
    tbl.push_back(mk(16'h0000, 6'd3, 0, 16'h0040, 0, 6, 0, 0, 1));
    tbl.push_back(mk(16'h0000, 6'd3, 1, 16'h0040, 1, 6, 0, 0, 1));
    tbl.push_back(mk(16'h0000, 6'd3, 0, 16'h0040, 0, 6, 0, 0, 1));
    tbl.push_back(mk(16'h0000, 6'd3, 1, 16'h0040, 1, 6, 0, 1, 1));
    tbl.push_back(mk(16'h0000, 6'd3, 1, 16'h0000, 0, 0, 0, 0, 0));
    // Port 0 with illegal len 0: single sop+eop beat (ptr=7 wraps to 0).
    tbl.push_back(mk(16'h0001, 6'd0, 1, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(16'h0000, 6'd0, 1, 16'h0001, 1, 0, 1, 1, 1));
    tbl.push_back(mk(16'h0000, 6'd0, 1, 16'h0000, 0, 0, 0, 0, 0));
    // Port 5 len 4; ports 2,7 request mid-packet; then 7 (ptr=6), then 2.
    tbl.push_back(mk(16'h0020, 6'd4, 1, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(16'h0084, 6'd4, 1, 16'h0020, 1, 5, 1, 0, 1));
    tbl.push_back(mk(16'h0084, 6'd4, 1, 16'h0020, 1, 5, 0, 0, 1));
    tbl.push_back(mk(16'h0084, 6'd4, 1, 16'h0020, 1, 5, 0, 0, 1));
    tbl.push_back(mk(16'h0084, 6'd4, 1, 16'h0020, 1, 5, 0, 1, 1));
    tbl.push_back(mk(16'h0084, 6'd1, 1, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(16'h0004, 6'd1, 1, 16'h0080, 1, 7, 1, 1, 1));
    tbl.push_back(mk(16'h0004, 6'd1, 1, 16'h0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(16'h0000, 6'd1, 1, 16'h0004, 1, 2, 1, 1, 1));
    tbl.push_back(mk(16'h0000, 6'd1, 1, 16'h0000, 0, 0, 0, 0, 0));

    // Reset held with random requests and ready.
    for (int c = 0; c < 4; c++) begin
      set_in(16'($urandom), 6'($urandom_range(1, 63)), 1'($urandom));
      #2;
      chk_zero($sformatf("reset%0d", c));
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_in(16'h0, 6'd1, 1'b1);
    @(posedge clk);
    #1;

    // Table: inputs applied just after an edge, outputs checked before the next.
    for (int r = 0; r < tbl.size(); r++) begin
      set_in(tbl[r].req, tbl[r].len, tbl[r].rdy);
      #1;
      chk_out($sformatf("row%0d", r), tbl[r].grant, tbl[r].wr, tbl[r].port,
              tbl[r].sop, tbl[r].eop, tbl[r].busy);
      @(posedge clk);
      #1;
    end

    // Mid-packet asynchronous reset (ptr is 3 here, so port 9 wins).
    set_in(16'h0200, 6'd10, 1'b1);
    #1;
    chk_out("mr0", 16'h0000, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    set_in(16'h0000, 6'd10, 1'b1);
    #1;
    chk_out("mr1", 16'h0200, 1, 9, 1, 0, 1);
    @(posedge clk); #1;
    chk_out("mr2", 16'h0200, 1, 9, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mr_async");
    @(negedge clk);
    rst_n = 1'b1;
    // With ptr back at 0, port 0 must beat port 9.
    set_in(16'h0201, 6'd1, 1'b1);
    @(posedge clk); #1;
    set_in(16'h0000, 6'd1, 1'b1);
    #1;
    chk_out("mr_ptr", 16'h0001, 1, 0, 1, 1, 1);
    @(posedge clk); #1;
    chk_out("mr_idle", 16'h0000, 0, 0, 0, 0, 0);

    // Fairness: all ports requesting len 1 after reset, 34 cycles.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    set_in(16'hFFFF, 6'd1, 1'b1);
    @(posedge clk); #1;
    for (int c = 1; c <= 34; c++) begin
      #1;
      if (c % 2 == 1) begin
        chk_out($sformatf("fair%0d", c), 16'd1 << ((c / 2) % 16), 1, 4'((c / 2) % 16), 1, 1, 1);
        chk($sformatf("fair%0d onehot", c), 64'($onehot(ack)), 64'(1));
      end else begin
        chk_out($sformatf("fair%0d", c), 16'h0000, 0, 0, 0, 0, 0);
      end
      @(posedge clk); #1;
    end
    set_in(16'h0, 6'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
